// File: rtl/cmp_result_monitor_if.sv
// Sample/status bundle between the comparator-facing driver and cmp_result_monitor.
// master: drives in_valid/Eq/Gt/Sm and reads status; slave: the monitor itself.
// Pure wiring, no latency or backpressure of its own.
interface cmp_result_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             Eq;
    logic             Gt;
    logic             Sm;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] sm_cnt;
    logic [CNT_W-1:0] streak;
    logic [1:0]       last_res;
    logic             gt_alarm;
    logic             sm_alarm;
    logic             onehot_err;
    logic             out_valid;

    modport master (
        output in_valid, Eq, Gt, Sm,
        input  eq_cnt, gt_cnt, sm_cnt, streak, last_res,
        input  gt_alarm, sm_alarm, onehot_err, out_valid
    );

    modport slave (
        input  in_valid, Eq, Gt, Sm,
        output eq_cnt, gt_cnt, sm_cnt, streak, last_res,
        output gt_alarm, sm_alarm, onehot_err, out_valid
    );
endinterface

// File: rtl/cmp_result_monitor.sv
// Counts comparator outcomes, tracks runs of identical outcomes, raises sticky Gt/Sm run alarms and a one-hot error.
// Latency: 1 cycle, every output registered; out_valid pulses for each qualified sample.
// No backpressure: one sample per clock accepted whenever in_valid is high.
// Ports: clk, rst (sync, active high), clr (sync clear, same effect as rst),
//        bus.slave: in_valid/Eq/Gt/Sm in; counters, streak, last_res, alarms, onehot_err, out_valid out.
module cmp_result_monitor #(
    parameter int CNT_W      = 8,
    parameter int STREAK_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    cmp_result_monitor_if.slave  bus
);
    // State encoding equals the last_res encoding, so last_res is the state flop itself.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EQ   = 2'b01;
    localparam logic [1:0] S_GT   = 2'b10;
    localparam logic [1:0] S_SM   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STREAK_TGT = CNT_W'(STREAK_LEN);

    logic [1:0]       state;
    logic [CNT_W-1:0] eq_cnt, gt_cnt, sm_cnt, streak;
    logic             gt_alarm, sm_alarm, onehot_err, out_valid;

    logic [2:0]       vec;
    logic             onehot;
    logic [1:0]       outcome;
    logic [CNT_W-1:0] streak_nxt;

    assign vec    = {bus.Eq, bus.Gt, bus.Sm};
    assign onehot = (vec == 3'b100) || (vec == 3'b010) || (vec == 3'b001);

    always_comb begin
        outcome = S_SM;
        if (bus.Eq)      outcome = S_EQ;
        else if (bus.Gt) outcome = S_GT;
    end

    // A run continues only if the previous accepted outcome matches; IDLE never matches.
    always_comb begin
        streak_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
        if (state == outcome)
            streak_nxt = (streak == CNT_MAX) ? streak : streak + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= S_IDLE;
            eq_cnt     <= '0;
            gt_cnt     <= '0;
            sm_cnt     <= '0;
            streak     <= '0;
            gt_alarm   <= 1'b0;
            sm_alarm   <= 1'b0;
            onehot_err <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                if (onehot) begin
                    state  <= outcome;
                    streak <= streak_nxt;
                    case (outcome)
                        S_EQ:    if (eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
                        S_GT:    if (gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
                        default: if (sm_cnt != CNT_MAX) sm_cnt <= sm_cnt + 1'b1;
                    endcase
                    // Alarms only set; a saturated streak holding at the target just re-asserts a set flag.
                    if (outcome == S_GT && streak_nxt == STREAK_TGT) gt_alarm <= 1'b1;
                    if (outcome == S_SM && streak_nxt == STREAK_TGT) sm_alarm <= 1'b1;
                end else begin
                    onehot_err <= 1'b1;
                    state      <= S_IDLE;
                    streak     <= '0;
                end
            end
        end
    end

    assign bus.eq_cnt     = eq_cnt;
    assign bus.gt_cnt     = gt_cnt;
    assign bus.sm_cnt     = sm_cnt;
    assign bus.streak     = streak;
    assign bus.last_res   = state;
    assign bus.gt_alarm   = gt_alarm;
    assign bus.sm_alarm   = sm_alarm;
    assign bus.onehot_err = onehot_err;
    assign bus.out_valid  = out_valid;
endmodule

// File: tb/tb_cmp_result_monitor.sv
module tb_cmp_result_monitor;
    logic       clk = 1'b0;
    logic       rst, clr, in_valid, eq, gt, sm;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    cmp_result_monitor_if #(.CNT_W(8)) ifa ();
    cmp_result_monitor_if #(.CNT_W(4)) ifb ();

    assign ifa.in_valid = in_valid;
    assign ifa.Eq = eq;
    assign ifa.Gt = gt;
    assign ifa.Sm = sm;
    assign ifb.in_valid = in_valid;
    assign ifb.Eq = eq;
    assign ifb.Gt = gt;
    assign ifb.Sm = sm;

    cmp_result_monitor #(.CNT_W(8), .STREAK_LEN(4)) dut_a (.clk(clk), .rst(rst), .clr(clr), .bus(ifa));
    cmp_result_monitor #(.CNT_W(4), .STREAK_LEN(4)) dut_b (.clk(clk), .rst(rst), .clr(clr), .bus(ifb));

    // Observed status packed into 8-bit slots: eq, gt, sm, streak, last_res, {ga,sa,err,ov}.
    logic [47:0] obs_a, obs_b;
    assign obs_a = {ifa.eq_cnt, ifa.gt_cnt, ifa.sm_cnt, ifa.streak, 6'b0, ifa.last_res,
                    4'b0, ifa.gt_alarm, ifa.sm_alarm, ifa.onehot_err, ifa.out_valid};
    assign obs_b = {4'b0, ifb.eq_cnt, 4'b0, ifb.gt_cnt, 4'b0, ifb.sm_cnt, 4'b0, ifb.streak,
                    6'b0, ifb.last_res, 4'b0, ifb.gt_alarm, ifb.sm_alarm, ifb.onehot_err, ifb.out_valid};

    // Reference model: plain counts, the last accepted outcome (0 none, 1 Eq, 2 Gt, 3 Sm) and run length.
    typedef struct {
        int eq, gt, sm, run, last;
        bit ga, sa, err, ov;
    } m_t;

    m_t ma, mb;

    localparam bit [2:0] V_EQ = 3'b100;
    localparam bit [2:0] V_GT = 3'b010;
    localparam bit [2:0] V_SM = 3'b001;

    function automatic int min2(int x, int y);
        return (x < y) ? x : y;
    endfunction

    function automatic m_t model(m_t m, int maxv, int slen, bit v, bit [2:0] vec, bit c, bit r);
        m_t n;
        int o;
        n = m;
        if (r || c) begin
            n = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            n.ov = v;
            if (v) begin
                if (vec == V_EQ || vec == V_GT || vec == V_SM) begin
                    o = (vec == V_EQ) ? 1 : (vec == V_GT) ? 2 : 3;
                    n.run  = (m.last == o) ? min2(m.run + 1, maxv) : 1;
                    n.last = o;
                    if (o == 1) n.eq = min2(m.eq + 1, maxv);
                    if (o == 2) n.gt = min2(m.gt + 1, maxv);
                    if (o == 3) n.sm = min2(m.sm + 1, maxv);
                    if (o == 2 && n.run == slen) n.ga = 1'b1;
                    if (o == 3 && n.run == slen) n.sa = 1'b1;
                end else begin
                    n.err  = 1'b1;
                    n.last = 0;
                    n.run  = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [47:0] pk(m_t m);
        return {8'(m.eq), 8'(m.gt), 8'(m.sm), 8'(m.run), 6'b0, 2'(m.last),
                4'b0, m.ga, m.sa, m.err, m.ov};
    endfunction

    task automatic step(input bit v, input bit [2:0] vec, input bit c, input bit r);
        @(negedge clk);
        rst = r;
        clr = c;
        in_valid = v;
        {eq, gt, sm} = vec;
        @(posedge clk);
        #1;
        ma = model(ma, 255, 4, v, vec, c, r);
        mb = model(mb, 15, 4, v, vec, c, r);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 3'($urandom), 1'($urandom), 1'b1);
            total++;
            if (obs_a !== 48'h0) begin
                bad++;
                $display("FAIL reset_a cycle %0d got=%h want=%h", i, obs_a, 48'h0);
            end
            total++;
            if (obs_b !== 48'h0) begin
                bad++;
                $display("FAIL reset_b cycle %0d got=%h want=%h", i, obs_b, 48'h0);
            end
        end
    endtask

    task automatic test_run_break();
        bit [2:0] seq [6] = '{V_EQ, V_GT, V_GT, V_GT, V_GT, V_SM};
        int       exp_st [6] = '{1, 1, 2, 3, 4, 1};
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i], 1'b0, 1'b0);
            total++;
            if (obs_a !== pk(ma)) begin
                bad++;
                $display("FAIL run_break_model s%0d got=%h want=%h", i, obs_a, pk(ma));
            end
            total++;
            if (int'(ifa.streak) != exp_st[i] || ifa.gt_alarm !== (i >= 4)) begin
                bad++;
                $display("FAIL run_break_streak s%0d got streak=%0d ga=%b want streak=%0d ga=%b",
                         i, ifa.streak, ifa.gt_alarm, exp_st[i], (i >= 4));
            end
        end
        total++;
        if ({ifa.eq_cnt, ifa.gt_cnt, ifa.sm_cnt} !== {8'd1, 8'd4, 8'd1}) begin
            bad++;
            $display("FAIL run_break_counts got=%0d/%0d/%0d want=1/4/1", ifa.eq_cnt, ifa.gt_cnt, ifa.sm_cnt);
        end
    endtask

    task automatic test_invalid();
        bit [2:0] seq [6] = '{V_SM, V_SM, V_SM, 3'b110, 3'b000, V_SM};
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i], 1'b0, 1'b0);
            total++;
            if (obs_a !== pk(ma) || obs_b !== pk(mb)) begin
                bad++;
                $display("FAIL invalid_model s%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, pk(ma), pk(mb));
            end
            if (i == 3 || i == 4) begin
                total++;
                if ({ifa.onehot_err, ifa.streak, ifa.last_res, ifa.sm_cnt, ifa.out_valid} !== {1'b1, 8'd0, 2'b00, 8'd3, 1'b1}) begin
                    bad++;
                    $display("FAIL invalid_flags s%0d got err=%b st=%0d last=%b sm=%0d ov=%b want 1/0/00/3/1",
                             i, ifa.onehot_err, ifa.streak, ifa.last_res, ifa.sm_cnt, ifa.out_valid);
                end
            end
        end
        total++;
        if (ifa.streak !== 8'd1 || ifa.sm_alarm !== 1'b0) begin
            bad++;
            $display("FAIL invalid_recover got st=%0d sa=%b want st=1 sa=0", ifa.streak, ifa.sm_alarm);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, V_EQ, 1'b0, 1'b0);
            total++;
            if (obs_b !== pk(mb) || obs_a !== pk(ma)) begin
                bad++;
                $display("FAIL sat_model s%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, pk(ma), pk(mb));
            end
        end
        total++;
        if ({ifb.eq_cnt, ifb.streak, ifb.gt_alarm, ifb.sm_alarm, ifa.eq_cnt} !== {4'd15, 4'd15, 1'b0, 1'b0, 8'd20}) begin
            bad++;
            $display("FAIL sat_final got eq4=%0d st4=%0d ga=%b sa=%b eq8=%0d want 15/15/0/0/20",
                     ifb.eq_cnt, ifb.streak, ifb.gt_alarm, ifb.sm_alarm, ifa.eq_cnt);
        end
    endtask

    task automatic test_clr_collision();
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, V_GT, 1'b0, 1'b0);
        total++;
        if (ifa.gt_alarm !== 1'b1 || obs_a !== pk(ma)) begin
            bad++;
            $display("FAIL clr_setup got=%h want=%h", obs_a, pk(ma));
        end
        step(1'b1, V_GT, 1'b1, 1'b0);
        total++;
        if (obs_a !== 48'h0 || obs_b !== 48'h0) begin
            bad++;
            $display("FAIL clr_collision got=%h/%h want=0/0", obs_a, obs_b);
        end
        step(1'b1, V_GT, 1'b0, 1'b0);
        total++;
        if (ifa.gt_cnt !== 8'd1 || ifa.streak !== 8'd1 || obs_a !== pk(ma)) begin
            bad++;
            $display("FAIL clr_after got gt=%0d st=%0d want gt=1 st=1", ifa.gt_cnt, ifa.streak);
        end
    endtask

    task automatic test_gating_and_rst();
        step(1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b1, V_GT, 1'b0, 1'b0);
        step(1'b1, 3'b011, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3'($urandom), 1'b0, 1'b0);
            total++;
            if (obs_a !== pk(ma) || obs_b !== pk(mb)) begin
                bad++;
                $display("FAIL gating c%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, pk(ma), pk(mb));
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, V_SM, 1'b0, 1'b0);
        step(1'b1, V_SM, 1'b0, 1'b1);
        total++;
        if (obs_a !== 48'h0 || obs_b !== 48'h0) begin
            bad++;
            $display("FAIL rst_mid_run got=%h/%h want=0/0", obs_a, obs_b);
        end
    endtask

    task automatic test_back_to_back_random();
        bit [2:0] vec;
        bit       v, c, r;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 9))
                0:       vec = 3'($urandom);
                1, 2, 3: vec = V_EQ;
                4, 5, 6: vec = V_GT;
                default: vec = V_SM;
            endcase
            c = ($urandom_range(0, 60) == 0);
            r = ($urandom_range(0, 120) == 0);
            step(v, vec, c, r);
            total++;
            if (obs_a !== pk(ma) || obs_b !== pk(mb)) begin
                bad++;
                $display("FAIL random c%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, pk(ma), pk(mb));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        {eq, gt, sm} = 3'b000;
        ma = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        mb = ma;
        test_reset();
        test_run_break();
        test_invalid();
        test_saturation();
        test_clr_collision();
        test_gating_and_rst();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmp_result_monitor.md
# cmp_result_monitor

Sequential monitor that sits directly downstream of the 4-bit comparator and consumes its Eq/Gt/Sm flags one sample per qualified cycle. It keeps saturating per-outcome counters and tracks runs of identical outcomes with a small state machine. It raises sticky alarms when A>B or A<B persists for STREAK_LEN consecutive samples, and flags any non-one-hot flag vector as a protocol error. All outputs are registered for the status/register-read stage.

## Interface
- CNT_W, default 8: width of the outcome counters and the streak counter.
- STREAK_LEN, default 4: run length that triggers an alarm; legal range 2 to 2^CNT_W-1.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  Eq/Gt/Sm are sampled on this cycle.
- Eq  input  1  comparator equal flag.
- Gt  input  1  comparator greater-than flag.
- Sm  input  1  comparator smaller-than flag.
- clr  input  1  synchronous clear of counters, streak, alarms and error; same effect as rst.
- eq_cnt  output  CNT_W  accepted Eq samples, saturating.
- gt_cnt  output  CNT_W  accepted Gt samples, saturating.
- sm_cnt  output  CNT_W  accepted Sm samples, saturating.
- streak  output  CNT_W  length of the current run of identical outcomes, saturating.
- last_res  output  2  last accepted outcome: 00 = none, 01 = Eq, 10 = Gt, 11 = Sm.
- gt_alarm  output  1  sticky flag for a Gt run of at least STREAK_LEN.
- sm_alarm  output  1  sticky flag for an Sm run of at least STREAK_LEN.
- onehot_err  output  1  sticky flag for a qualified sample that was not one-hot.
- out_valid  output  1  one-cycle pulse; outputs reflect a newly processed sample.

## Operation
- **Valid sample.** A sample is valid when in_valid=1 and {Eq,Gt,Sm} is exactly one-hot: 100, 010 or 001.
- **Invalid sample.** A sample is invalid when in_valid=1 and the vector is 000, or has two or more bits set.
- **FSM states.** IDLE, RUN_EQ, RUN_GT, RUN_SM. IDLE is the state after rst or clr, with last_res=00 and streak=0.
- **Transitions on a valid sample:**
  - Move to RUN_x for outcome x.
  - If the state was already RUN_x, streak increments, saturating at 2^CNT_W-1.
  - Otherwise streak loads 1.
  - The matching counter increments, saturating at 2^CNT_W-1.
  - last_res is updated.
- **Invalid sample:**
  - onehot_err sets.
  - FSM returns to IDLE, streak clears to 0, last_res becomes 00.
  - No counter changes.
  - out_valid still pulses.
- **in_valid=0:** no state change; out_valid=0.
- **Alarms:**
  - gt_alarm sets on the update where the state is RUN_GT and the new streak equals STREAK_LEN. sm_alarm does the same for RUN_SM.
  - Runs of Eq never alarm.
  - Alarms, once set, stay set until rst or clr, even if the run breaks.
  - Saturation of streak never clears or re-triggers an alarm.
- **rst/clr effect:** all outputs go to 0, FSM goes to IDLE. When clr and in_valid are both high in the same cycle, clr wins, the sample is dropped, and out_valid=0.
- **Reset priority:** rst has priority over clr. Asserting rst mid-run discards the run with no partial update.

## Timing
- Every output is a flop; there is no combinational path from input to output.
- Latency is 1 cycle: a sample accepted at edge N is visible on all outputs after edge N, together with out_valid=1 for that single cycle.
- Back-to-back samples are accepted every cycle; throughput is 1 sample per clock; there is no backpressure.
- Reset values: eq_cnt, gt_cnt, sm_cnt, streak = 0; last_res = 00; gt_alarm, sm_alarm, onehot_err, out_valid = 0.
- Counter saturation: at value 2^CNT_W-1 a further matching sample leaves the count unchanged. Other fields still update.
- Alarm set timing: an alarm rises in the same cycle that streak shows STREAK_LEN.

## Test plan
- **Reset values:** hold rst for 2 cycles with random inputs -> every output is 0, last_res=00.
- **Run break and Gt alarm (CNT_W=8, STREAK_LEN=4):**
  - Stimulus: samples Eq, Gt, Gt, Gt, Gt, Sm, one per cycle.
  - Streak sequence is 1, 1, 2, 3, 4, 1.
  - gt_alarm rises after the 5th sample and stays 1 after the Sm sample.
  - Final counts: eq_cnt=1, gt_cnt=4, sm_cnt=1.
- **Invalid vectors:**
  - Send 110, then 000, each with in_valid=1, after a run of 3 Sm -> onehot_err=1, streak=0, last_res=00, sm_cnt stays 3, and out_valid pulses for both samples.
  - A following Sm sample gives streak=1, with no sm_alarm.
- **Saturation (CNT_W=4):** 20 consecutive Eq samples -> eq_cnt=15 and streak=15, then both hold. gt_alarm and sm_alarm stay 0.
- **clr collision:** assert clr together with a valid Gt sample while gt_alarm=1 -> next cycle all outputs are 0 and out_valid=0. The following Gt sample gives gt_cnt=1, streak=1.
- **in_valid gating and rst mid-run:**
  - Toggle Eq/Gt/Sm randomly with in_valid=0 -> no output changes.
  - Assert rst during an Sm run of 3 -> all outputs are 0 on the next cycle.
